// File: rtl/pipe_scheduler.sv
// pipe_scheduler: run-state FSM, scroll tick, pipe positions/gaps and pass score for Flappy Bird.
module pipe_scheduler #(
    parameter int TICK_DIV = 500000,
    parameter int X_START  = 784,
    parameter int X_LEFT   = 144,
    parameter int PIPE_W   = 40,
    parameter int SPACING  = 320,
    parameter int Y_MIN    = 135
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Ack,
    input  logic        Lost,
    input  logic [9:0]  BirdX,
    output logic [9:0]  PipeX1,
    output logic [9:0]  PipeY1,
    output logic [9:0]  PipeX2,
    output logic [9:0]  PipeY2,
    output logic        PipeEn1,
    output logic        PipeEn2,
    output logic [15:0] Score,
    output logic        ScorePulse,
    output logic        q_I,
    output logic        q_Run,
    output logic        q_Over
);
    localparam int CW = $clog2(TICK_DIV + 1);
    localparam logic [9:0] XS = 10'(X_START);
    localparam logic [9:0] XW = 10'(X_LEFT - PIPE_W);
    localparam logic [9:0] XE = 10'(X_START - SPACING);
    localparam logic [9:0] YM = 10'(Y_MIN);

    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [15:0]   lfsr_q, lfsr_d, score_q, score_d;
    logic [9:0]    x1_q, x2_q, y1_q, y2_q, nx1, nx2, y_new;
    logic          en1_q, en2_q, pulse_q, tick, hit1, hit2;
    logic [16:0]   sum;

    assign lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign y_new   = YM + {2'b00, lfsr_q[7:0]};
    assign tick    = (state_q == RUN) && (cnt_q == CW'(TICK_DIV - 1));
    assign hit1    = en1_q && (({1'b0, x1_q} + 11'(PIPE_W)) == {1'b0, BirdX});
    assign hit2    = en2_q && (({1'b0, x2_q} + 11'(PIPE_W)) == {1'b0, BirdX});
    assign sum     = {1'b0, score_q} + 17'(hit1) + 17'(hit2);
    assign score_d = sum[16] ? 16'hFFFF : sum[15:0];
    assign nx1     = (x1_q == XW) ? XS : x1_q - 10'd1;
    assign nx2     = (x2_q == XW) ? XS : x2_q - 10'd1;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lfsr_q  <= 16'hACE1;
            x1_q    <= XS;
            x2_q    <= XS;
            y1_q    <= YM;
            y2_q    <= YM;
            en1_q   <= 1'b0;
            en2_q   <= 1'b0;
            score_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            pulse_q <= 1'b0;
            case (state_q)
                IDLE: if (Start) begin
                    state_q <= RUN;
                    score_q <= '0;
                    en1_q   <= 1'b1;
                    y1_q    <= y_new;
                    cnt_q   <= '0;
                end
                RUN: if (Lost) begin
                    state_q <= OVER;
                end else begin
                    cnt_q <= tick ? '0 : cnt_q + 1'b1;
                    if (tick) begin
                        if (en1_q) begin
                            x1_q <= nx1;
                            if (x1_q == XW) y1_q <= y_new;
                        end
                        // pipe 2 is enabled once, the first time pipe 1 crosses the spacing mark
                        if (en2_q) begin
                            x2_q <= nx2;
                            if (x2_q == XW) y2_q <= y_new;
                        end else if (en1_q && x1_q == XE) begin
                            en2_q <= 1'b1;
                            y2_q  <= y_new;
                        end
                        if (hit1 || hit2) begin
                            score_q <= score_d;
                            pulse_q <= 1'b1;
                        end
                    end
                end
                OVER: if (Ack) begin
                    state_q <= IDLE;
                    x1_q    <= XS;
                    x2_q    <= XS;
                    y1_q    <= YM;
                    y2_q    <= YM;
                    en1_q   <= 1'b0;
                    en2_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign PipeX1     = x1_q;
    assign PipeY1     = y1_q;
    assign PipeX2     = x2_q;
    assign PipeY2     = y2_q;
    assign PipeEn1    = en1_q;
    assign PipeEn2    = en2_q;
    assign Score      = score_q;
    assign ScorePulse = pulse_q;
    assign q_I        = state_q == IDLE;
    assign q_Run      = state_q == RUN;
    assign q_Over     = state_q == OVER;
endmodule

// File: tb/tb_pipe_scheduler.sv
// tb_pipe_scheduler: randomized run of pipe_scheduler against a cycle-level behavioural game model.
module tb_pipe_scheduler;
    localparam int TD = 4;

    logic        Clk = 1'b0, Reset = 1'b0, Start = 1'b0, Ack = 1'b0, Lost = 1'b0;
    logic [9:0]  BirdX = 10'd300;
    logic [9:0]  PipeX1, PipeY1, PipeX2, PipeY2;
    logic        PipeEn1, PipeEn2, ScorePulse, q_I, q_Run, q_Over;
    logic [15:0] Score;

    int tests = 0, fails = 0;

    pipe_scheduler #(.TICK_DIV(TD)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .Lost(Lost), .BirdX(BirdX),
        .PipeX1(PipeX1), .PipeY1(PipeY1), .PipeX2(PipeX2), .PipeY2(PipeY2),
        .PipeEn1(PipeEn1), .PipeEn2(PipeEn2), .Score(Score), .ScorePulse(ScorePulse),
        .q_I(q_I), .q_Run(q_Run), .q_Over(q_Over)
    );

    always #5 Clk = ~Clk;

    // model: 0 idle, 1 run, 2 over
    int          m_state, m_x1, m_x2, m_y1, m_y2, m_score, m_run_cyc;
    bit          m_en1, m_en2, m_pulse, m_tick;
    logic [15:0] m_lfsr;

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_x1 = 784; m_x2 = 784; m_y1 = 135; m_y2 = 135;
        m_en1 = 0; m_en2 = 0; m_score = 0; m_pulse = 0; m_run_cyc = 0; m_lfsr = 16'hACE1;
    endtask

    task automatic model_step();
        int  ynew, inc;
        bit  open2;
        ynew    = 135 + int'(m_lfsr[7:0]);
        m_lfsr  = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        m_pulse = 0;
        m_tick  = 0;
        if (m_state == 0 && Start) begin
            m_state = 1; m_score = 0; m_en1 = 1; m_y1 = ynew; m_run_cyc = 0;
        end else if (m_state == 1 && Lost) begin
            m_state = 2;
        end else if (m_state == 1) begin
            m_tick = (m_run_cyc % TD) == TD - 1;
            m_run_cyc++;
            if (m_tick) begin
                inc = 0;
                if (m_en1 && m_x1 + 40 == int'(BirdX)) inc++;
                if (m_en2 && m_x2 + 40 == int'(BirdX)) inc++;
                if (inc > 0) begin
                    m_score = (m_score + inc > 65535) ? 65535 : m_score + inc;
                    m_pulse = 1;
                end
                open2 = !m_en2 && m_en1 && m_x1 == 464;
                if (m_en1) begin
                    if (m_x1 == 104) begin m_x1 = 784; m_y1 = ynew; end
                    else m_x1--;
                end
                if (m_en2) begin
                    if (m_x2 == 104) begin m_x2 = 784; m_y2 = ynew; end
                    else m_x2--;
                end
                if (open2) begin m_en2 = 1; m_y2 = ynew; end
            end
        end else if (m_state == 2 && Ack) begin
            m_state = 0; m_x1 = 784; m_x2 = 784; m_y1 = 135; m_y2 = 135; m_en1 = 0; m_en2 = 0;
        end
    endtask

    task automatic compare_all();
        check("x1", PipeX1, m_x1);
        check("y1", PipeY1, m_y1);
        check("x2", PipeX2, m_x2);
        check("y2", PipeY2, m_y2);
        check("en1", PipeEn1, m_en1);
        check("en2", PipeEn2, m_en2);
        check("score", Score, m_score);
        check("pulse", ScorePulse, m_pulse);
        check("q_I", q_I, m_state == 0);
        check("q_Run", q_Run, m_state == 1);
        check("q_Over", q_Over, m_state == 2);
    endtask

    task automatic step();
        model_step();
        @(posedge Clk);
        @(negedge Clk);
        compare_all();
    endtask

    task automatic run_cycles(input int n, input bit noise);
        for (int i = 0; i < n; i++) begin
            if (noise) begin
                Start = ($urandom_range(0, 15) == 0) && m_state != 0;
                Ack   = ($urandom_range(0, 15) == 0) && m_state != 2;
            end
            step();
        end
        Start = 0;
        Ack   = 0;
    endtask

    task automatic async_reset();
        Reset = 0;
        #1;
        model_reset();
        compare_all();
        @(negedge Clk);
        compare_all();
        Reset = 1;
    endtask

    task automatic start_run();
        Start = 1;
        step();
        Start = 0;
        check("y1_range", int'(PipeY1 >= 10'd135 && PipeY1 <= 10'd390), 1);
    endtask

    initial begin
        model_reset();
        @(negedge Clk);
        compare_all();
        Reset = 1;
        run_cycles($urandom_range(3, 40), 0);
        start_run();
        run_cycles(3, 0);
        check("x1_first_move_pending", PipeX1, 784);
        step();
        check("x1_after_4", PipeX1, 783);
        run_cycles(4, 0);
        check("x1_after_8", PipeX1, 782);
        // pipe 1 crosses the bird at 260, reaches 104, respawns; pipe 2 opens at 464
        run_cycles(TD * 700, 1);
        check("en2_opened", PipeEn2, 1);
        check("scored", int'(Score >= 16'd1), 1);
        // Lost coincident with a tick
        while (m_run_cyc % TD != TD - 1) step();
        Lost = 1;
        step();
        Lost = 0;
        check("over_state", q_Over, 1);
        Start = 1;
        run_cycles(3, 0);
        check("start_ignored_over", q_Over, 1);
        Ack = 1;
        step();
        Ack = 0;
        check("ack_idle", q_I, 1);
        run_cycles($urandom_range(2, 20), 0);
        start_run();
        check("score_cleared", Score, 0);
        // randomized bird positions across a second run
        for (int k = 0; k < 4; k++) begin
            BirdX = 10'($urandom_range(150, 700));
            run_cycles(TD * 200, 1);
        end
        // saturation: preload near the top and keep passing pipes
        BirdX = 10'd300;
        force dut.score_q = 16'hFFFE;
        #1;
        release dut.score_q;
        m_score = 16'hFFFE;
        for (int i = 0; i < TD * 1400; i++) begin
            step();
            if (m_pulse && m_score == 65535) check("sat_pulse", ScorePulse, 1);
        end
        check("sat_score", Score, 16'hFFFF);
        // reset mid-run
        run_cycles($urandom_range(1, 30), 0);
        check("mid_run", q_Run, 1);
        async_reset();
        check("rst_qI", q_I, 1);
        check("rst_x1", PipeX1, 784);
        run_cycles(5, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
